// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: write-back source handshakes and register-file write ports
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int NR_WB_SOURCES  = 4,
    parameter int NR_WRITE_PORTS = 2
);
    logic [NR_WB_SOURCES-1:0]             wb_valid_i;
    logic [NR_WB_SOURCES-1:0]             wb_ready_o;
    logic [NR_WB_SOURCES*5-1:0]           wb_waddr_i;
    logic [NR_WB_SOURCES*DATA_WIDTH-1:0]  wb_wdata_i;
    logic [NR_WRITE_PORTS*5-1:0]          waddr_o;
    logic [NR_WRITE_PORTS*DATA_WIDTH-1:0] wdata_o;
    logic [NR_WRITE_PORTS-1:0]            we_o;
    logic                                 busy_o;

    modport slave (
        input  wb_valid_i, wb_waddr_i, wb_wdata_i,
        output wb_ready_o, waddr_o, wdata_o, we_o, busy_o
    );

    modport master (
        output wb_valid_i, wb_waddr_i, wb_wdata_i,
        input  wb_ready_o, waddr_o, wdata_o, we_o, busy_o
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: buffers one result per write-back source and grants up to
// NR_WRITE_PORTS conflict-free, non-x0 register-file writes per cycle round-robin
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH     = 64,
    parameter int NR_WB_SOURCES  = 4,
    parameter int NR_WRITE_PORTS = 2
) (
    input logic                 clk_i,
    input logic                 rst_i,
    regfile_wb_arbiter_if.slave bus
);
    localparam int N  = NR_WB_SOURCES;
    localparam int P  = NR_WRITE_PORTS;
    localparam int PW = N > 1 ? $clog2(N) : 1;

    logic [N-1:0]            full_q, grant, ready;
    logic [4:0]              addr_q [N];
    logic [DATA_WIDTH-1:0]   data_q [N];
    logic [PW-1:0]           rr_q, rr_d;
    logic [4:0]              port_addr [P];
    logic [DATA_WIDTH-1:0]   port_data [P];
    logic [P-1:0]            port_we, we_q;
    logic [P*5-1:0]          waddr_q;
    logic [P*DATA_WIDTH-1:0] wdata_q;
    logic                    clash;
    int                      cnt, idx, last;

    assign ready          = ~full_q | grant;
    assign bus.wb_ready_o = ready;
    assign bus.busy_o     = |full_q;
    assign bus.we_o       = we_q;
    assign bus.waddr_o    = waddr_q;
    assign bus.wdata_o    = wdata_q;

    // x0 entries are granted only to free their slot; they never take a port
    always_comb begin
        grant   = '0;
        port_we = '0;
        cnt     = 0;
        idx     = 0;
        last    = 0;
        clash   = 1'b0;
        for (int k = 0; k < P; k++) begin
            port_addr[k] = '0;
            port_data[k] = '0;
        end
        for (int i = 0; i < N; i++) begin
            idx   = (int'(rr_q) + i) % N;
            clash = 1'b0;
            for (int k = 0; k < P; k++)
                clash |= port_we[k] && port_addr[k] == addr_q[idx];
            if (full_q[idx] && addr_q[idx] == 5'd0)
                grant[idx] = 1'b1;
            else if (full_q[idx] && cnt < P && !clash) begin
                grant[idx]     = 1'b1;
                port_we[cnt]   = 1'b1;
                port_addr[cnt] = addr_q[idx];
                port_data[cnt] = data_q[idx];
                last           = idx;
                cnt++;
            end
        end
        rr_d = cnt != 0 ? PW'((last + 1) % N) : rr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q  <= '0;
            rr_q    <= '0;
            we_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            for (int s = 0; s < N; s++) begin
                if (bus.wb_valid_i[s] && ready[s]) begin
                    full_q[s] <= 1'b1;
                    addr_q[s] <= bus.wb_waddr_i[s*5+:5];
                    data_q[s] <= bus.wb_wdata_i[s*DATA_WIDTH+:DATA_WIDTH];
                end else if (grant[s]) begin
                    full_q[s] <= 1'b0;
                end
            end
            rr_q <= rr_d;
            for (int k = 0; k < P; k++) begin
                we_q[k]                            <= port_we[k];
                waddr_q[k*5+:5]                    <= port_addr[k];
                wdata_q[k*DATA_WIDTH+:DATA_WIDTH]  <= port_data[k];
            end
        end
    end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter sitting in front of the multi-write-port integer/FP register file. It collects results from NR_WB_SOURCES functional units over valid/ready handshakes, buffers one result per source, and grants up to NR_WRITE_PORTS writes per cycle in round-robin order. It drives the register file's per-port write address, data and enable from registers. It guarantees the register file never receives two same-cycle writes to one address and never receives a write to x0.

## Interface
Parameters:
- DATA_WIDTH, 64, register data width
- NR_WB_SOURCES, 4, number of write-back sources (>= 2)
- NR_WRITE_PORTS, 2, register file write ports (1 .. NR_WB_SOURCES)

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock domain, reset is synchronous and active-high
- wb_valid_i  in  NR_WB_SOURCES  per-source result valid
- wb_ready_o  out  NR_WB_SOURCES  per-source accept
- wb_waddr_i  in  NR_WB_SOURCES*5  per-source destination register, source s at [s*5+:5]
- wb_wdata_i  in  NR_WB_SOURCES*DATA_WIDTH  per-source result data
- waddr_o  out  NR_WRITE_PORTS*5  register file write address per port
- wdata_o  out  NR_WRITE_PORTS*DATA_WIDTH  register file write data per port
- we_o  out  NR_WRITE_PORTS  register file write enable per port
- busy_o  out  1  any holding slot occupied

## Operation
- Each source owns one holding slot (full, addr, data). Transfer occurs when wb_valid_i[s] & wb_ready_o[s] at a rising edge.
- wb_ready_o[s] = !full[s] | grant[s]. A granted slot refills in the same cycle, giving one result per source per cycle.
- Entries with addr == 0 are discarded. On the cycle such an entry is held, the slot is cleared. It takes no port and produces no we_o. grant[s] is asserted for it so that ready stays high.
- Arbitration is combinational from slot state and the pointer rr_q (width max(1,$clog2(NR_WB_SOURCES))):
  - Scan sources rr_q, rr_q+1, ... modulo NR_WB_SOURCES.
  - Grant a full, non-zero-address slot only if all of the following hold:
    - fewer than NR_WRITE_PORTS grants have been made this cycle;
    - its addr differs from every addr already granted this cycle.
  - A skipped conflicting slot stays full and is retried next cycle.
- The k-th granted source, in scan order, maps to port k. Registered outputs next edge:
  - we_o[k]=1, with waddr_o[k] and wdata_o[k] taken from that slot.
  - Ports without a grant: we_o=0, with waddr_o and wdata_o driven to 0.
- Pointer update: if at least one non-zero grant occurs, rr_q <= (index of last granted source + 1) mod NR_WB_SOURCES. Otherwise rr_q holds.
- busy_o = OR of full[] (combinational from slots).

## Timing
- Reset (rst_i high at an edge) clears:
  - all full bits;
  - rr_q=0;
  - we_o=0, waddr_o=0, wdata_o=0.
  - wb_ready_o is all-ones while slots are empty, and busy_o=0.
  - Reset asserted mid-operation discards held results. No write is emitted for them.
- Latency:
  - Result accepted at edge E0.
  - Slot full during cycle 1; granted in cycle 1 if uncontended.
  - we_o high during cycle 2. The register file commits at the edge closing cycle 2.
  - Minimum latency is 2 edges from handshake to register-file commit.
- Contention: a slot not granted holds and deasserts ready until granted. With all sources saturated, each source is granted at least once every ceil(NR_WB_SOURCES/NR_WRITE_PORTS) cycles.
- Same-address conflict in one cycle: only the first in scan order is written. The other is written in a later cycle. Ordering between different sources is not otherwise defined; the issue logic guarantees distinct in-flight destinations.
- wb_valid_i may drop without a handshake. Data is sampled only at the transfer edge.

## Test plan
- Reset, then a single result:
  - Stimulus: source 0 presents valid with addr 5, data 0xAA for one cycle.
  - Required response: one cycle of we_o[0]=1, waddr_o[0]=5, wdata_o[0]=0xAA two edges later; we_o otherwise 0; busy_o high for exactly one cycle.
- x0 drop: source 2 presents addr 0, data 0xFF. Required: wb_ready_o stays 1, we_o never asserts, busy_o pulses for one cycle.
- Saturation:
  - Stimulus: all 4 sources valid every cycle with distinct addresses 1-4, over 8 cycles.
  - Required grants in port order: {0,1}, {2,3}, {0,1}, ...
  - Required: each source's wb_ready_o toggles 1,0 alternately; both we_o bits high every cycle after fill.
- Address conflict: sources 0 and 1 both hold addr 7 (data 0x1 and 0x2), rr_q=0. Required: cycle A gives port 0 = (7, 0x1) and port 1 idle; cycle A+1 gives port 0 = (7, 0x2).
- Round-robin pointer:
  - Sources 3 and 0 are full with rr_q=3.
  - Required: port 0 takes source 3 and port 1 takes source 0; rr_q becomes 1.
- Reset mid-flight:
  - Stimulus: assert rst_i while 3 slots are full.
  - Required: next cycle we_o=0, busy_o=0, wb_ready_o all-ones, and no stale write appears afterwards.
